gmii_rx_frame_receiver: RTL and testbench

//  Receive side of the GMII loopback path. Takes raw GMII RX bytes from the PHY,

---
 rtl/gmii_rx_frame_receiver_pkg.sv | 9 +
 rtl/gmii_rx_frame_receiver_if.sv | 23 ++
 rtl/gmii_rx_frame_receiver_crc32_d8.sv | 15 +
 rtl/gmii_rx_frame_receiver.sv | 118 +++++++++++
 tb/tb_gmii_rx_frame_receiver.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/gmii_rx_frame_receiver_pkg.sv
// gmii_rx_frame_receiver_pkg: GMII framing constants, CRC-32 constants and the shared FSM state encoding
package gmii_rx_frame_receiver_pkg;
    localparam logic [7:0]  GMII_PRE      = 8'h55;
    localparam logic [7:0]  GMII_SFD      = 8'hD5;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;
    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    typedef enum logic [2:0] {IDLE, PRE, DATA, END, DROP} state_t;
endpackage

// File: rtl/gmii_rx_frame_receiver_if.sv
// gmii_rx_frame_receiver_if: GMII RX pins plus the received byte stream, status strobes and counters
interface gmii_rx_frame_receiver_if #(
    parameter int CNT_W = 16
);
    logic [7:0]       gmii_rxd;
    logic             gmii_rx_dv;
    logic             gmii_rx_er;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_sof;
    logic             rx_done;
    logic             rx_good;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] err_cnt;
    modport master (
        input  gmii_rxd, gmii_rx_dv, gmii_rx_er,
        output rx_data, rx_valid, rx_sof, rx_done, rx_good, frame_cnt, err_cnt
    );
    modport slave (
        output gmii_rxd, gmii_rx_dv, gmii_rx_er,
        input  rx_data, rx_valid, rx_sof, rx_done, rx_good, frame_cnt, err_cnt
    );
endinterface

// File: rtl/gmii_rx_frame_receiver_crc32_d8.sv
// gmii_rx_frame_receiver_crc32_d8: next CRC-32 state for one byte fed LSB first
module gmii_rx_frame_receiver_crc32_d8
    import gmii_rx_frame_receiver_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);
    // MSB-first register with LSB-first data: equals the reflected CRC bit-reversed, so a good frame leaves C704DD7B
    always_comb begin
        crc_next = crc;
        for (int i = 0; i < 8; i++)
            crc_next = {crc_next[30:0], 1'b0} ^ ((crc_next[31] ^ data[i]) ? CRC32_POLY : 32'h0);
    end
endmodule

// File: rtl/gmii_rx_frame_receiver.sv
// gmii_rx_frame_receiver: strips preamble/SFD, checks FCS and length, streams the frame without its FCS
module gmii_rx_frame_receiver
    import gmii_rx_frame_receiver_pkg::*;
#(
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518,
    parameter int CNT_W     = 16
) (
    input  logic clk,
    input  logic rst_n,
    gmii_rx_frame_receiver_if.master bus
);
    localparam int LEN_W = $clog2(MAX_FRAME + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [7:0]       rxd_q;
    logic             dv_q;
    logic             er_q;
    logic [31:0]      crc;
    logic [31:0]      crc_next;
    logic [LEN_W-1:0] len;
    logic             bad;
    logic             first;
    logic [3:0][7:0]  dly;
    logic [2:0]       fill;
    logic             good;

    gmii_rx_frame_receiver_crc32_d8 u_crc (.crc(crc), .data(rxd_q), .crc_next(crc_next));

    assign good = !bad && crc == CRC32_RESIDUE && len >= LEN_W'(MIN_FRAME) && len <= LEN_W'(MAX_FRAME);

    // Register the PHY pins once; everything downstream works on these copies
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rxd_q <= '0;
            dv_q  <= 1'b0;
            er_q  <= 1'b0;
        end else begin
            rxd_q <= bus.gmii_rxd;
            dv_q  <= bus.gmii_rx_dv;
            er_q  <= bus.gmii_rx_er;
        end
    end

    // Frame FSM; the 4-byte delay line holds back the FCS so it is never emitted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            crc           <= CRC32_INIT;
            len           <= '0;
            bad           <= 1'b0;
            first         <= 1'b0;
            dly           <= '0;
            fill          <= '0;
            bus.rx_data   <= '0;
            bus.rx_valid  <= 1'b0;
            bus.rx_sof    <= 1'b0;
            bus.rx_done   <= 1'b0;
            bus.rx_good   <= 1'b0;
            bus.frame_cnt <= '0;
            bus.err_cnt   <= '0;
        end else begin
            bus.rx_valid <= 1'b0;
            bus.rx_sof   <= 1'b0;
            bus.rx_done  <= 1'b0;
            bus.rx_good  <= 1'b0;
            case (state)
                IDLE: if (dv_q) state <= (rxd_q == GMII_PRE) ? PRE : DROP;
                PRE: begin
                    if (!dv_q)
                        state <= IDLE;
                    else if (rxd_q == GMII_SFD) begin
                        state <= DATA;
                        len   <= '0;
                        crc   <= CRC32_INIT;
                        bad   <= 1'b0;
                        first <= 1'b1;
                        fill  <= '0;
                    end else if (rxd_q != GMII_PRE)
                        state <= DROP;
                end
                DATA: begin
                    if (dv_q) begin
                        crc <= crc_next;
                        len <= (len == LEN_W'(MAX_FRAME + 1)) ? len : len + 1'b1;
                        dly <= {dly[2:0], rxd_q};
                        bad <= bad | er_q;
                        if (fill == 3'd4) begin
                            bus.rx_data  <= dly[3];
                            bus.rx_valid <= 1'b1;
                            bus.rx_sof   <= first;
                            first        <= 1'b0;
                        end else
                            fill <= fill + 1'b1;
                    end else
                        state <= END;
                end
                END: begin
                    bus.rx_done <= 1'b1;
                    bus.rx_good <= good;
                    if (good) begin
                        if (bus.frame_cnt != CNT_MAX) bus.frame_cnt <= bus.frame_cnt + 1'b1;
                    end else if (bus.err_cnt != CNT_MAX)
                        bus.err_cnt <= bus.err_cnt + 1'b1;
                    state <= (dv_q && rxd_q == GMII_PRE) ? PRE : IDLE;
                end
                DROP: begin
                    if (!dv_q) begin
                        if (bus.err_cnt != CNT_MAX) bus.err_cnt <= bus.err_cnt + 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gmii_rx_frame_receiver.sv
// tb_gmii_rx_frame_receiver: directed frames with a reference FCS, checked per scenario
module tb_gmii_rx_frame_receiver;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int vec = 0, miss = 0, cyc = 0;
    int da_cyc, dvlow_cyc;
    logic [7:0] fr[$];
    logic [7:0] got[$];
    int sof_idx, sof_cnt, done_cnt, good_cnt, last_good, first_valid_cyc, done_cyc, overlap;
    logic snap_any;
    logic [7:0] snap_data;
    logic [15:0] snap_cnt;

    gmii_rx_frame_receiver_if #(.CNT_W(16)) bus();
    gmii_rx_frame_receiver #(.MIN_FRAME(64), .MAX_FRAME(1518), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor on the falling edge
    always @(negedge clk) begin
        if (bus.rx_valid) begin
            if (bus.rx_sof) sof_idx = got.size();
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            got.push_back(bus.rx_data);
        end
        if (bus.rx_sof) sof_cnt++;
        if (bus.rx_done) begin
            done_cnt++;
            done_cyc = cyc;
            last_good = int'(bus.rx_good);
            if (bus.rx_good) good_cnt++;
        end
        if ((bus.rx_valid && bus.rx_done) || (bus.rx_sof && !bus.rx_valid)) overlap++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic clear_mon();
        got.delete();
        sof_idx = -1; sof_cnt = 0; done_cnt = 0; good_cnt = 0;
        last_good = -1; first_valid_cyc = -1; done_cyc = -1; overlap = 0;
    endtask

    task automatic drive(input logic dv, input logic [7:0] d, input logic er);
        @(posedge clk); #1;
        bus.gmii_rx_dv = dv; bus.gmii_rxd = d; bus.gmii_rx_er = er;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; bus.gmii_rx_dv = 1'b0; bus.gmii_rxd = 8'h00; bus.gmii_rx_er = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);
        clear_mon();
    endtask

    // Reflected CRC-32 (0xEDB88320, LSB first), returned as the FCS value
    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, fr[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic build_frame(input int n);
        logic [31:0] f;
        fr.delete();
        for (int i = 0; i < n; i++) fr.push_back(8'(i * 7 + 3));
        f = fcs_of(n);
        fr.push_back(f[7:0]); fr.push_back(f[15:8]); fr.push_back(f[23:16]); fr.push_back(f[31:24]);
    endtask

    task automatic send_frame(input int flip_idx, input int er_idx, input int rst_idx);
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < fr.size(); i++) begin
            @(posedge clk); #1;
            if (i == 0) da_cyc = cyc;
            bus.gmii_rx_dv = 1'b1;
            bus.gmii_rxd   = fr[i] ^ ((i == flip_idx) ? 8'h01 : 8'h00);
            bus.gmii_rx_er = (i == er_idx);
            if (rst_idx >= 0 && i == rst_idx) rst_n = 1'b0;
            if (rst_idx >= 0 && i == rst_idx + 1) begin
                rst_n = 1'b1;
                @(negedge clk);
                snap_any  = bus.rx_valid | bus.rx_sof | bus.rx_done | bus.rx_good;
                snap_data = bus.rx_data;
                snap_cnt  = bus.frame_cnt | bus.err_cnt;
            end
        end
        @(posedge clk); #1;
        dvlow_cyc = cyc;
        bus.gmii_rx_dv = 1'b0; bus.gmii_rxd = 8'h00; bus.gmii_rx_er = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; bus.gmii_rx_dv = 1'b1; bus.gmii_rxd = 8'h55; bus.gmii_rx_er = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vec++; if ({bus.rx_valid, bus.rx_sof, bus.rx_done, bus.rx_good} !== 4'b0) begin miss++; $display("FAIL reset_strobes got=%b exp=0000", {bus.rx_valid, bus.rx_sof, bus.rx_done, bus.rx_good}); end
        vec++; if (bus.rx_data !== 8'h00) begin miss++; $display("FAIL reset_data got=%h exp=00", bus.rx_data); end
        vec++; if (bus.frame_cnt !== 16'd0 || bus.err_cnt !== 16'd0) begin miss++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", bus.frame_cnt, bus.err_cnt); end
        bus.gmii_rx_dv = 1'b0;
    endtask

    task automatic test_good();
        int bad_bytes = 0;
        do_reset();
        build_frame(60);
        send_frame(-1, -1, -1);
        idle(8);
        for (int i = 0; i < got.size() && i < 60; i++) if (got[i] !== fr[i]) bad_bytes++;
        vec++; if (got.size() !== 60) begin miss++; $display("FAIL good_len got=%0d exp=60", got.size()); end
        vec++; if (bad_bytes !== 0) begin miss++; $display("FAIL good_data got=%0d bad bytes exp=0", bad_bytes); end
        vec++; if (sof_idx !== 0 || sof_cnt !== 1) begin miss++; $display("FAIL good_sof got=idx%0d cnt%0d exp=idx0 cnt1", sof_idx, sof_cnt); end
        vec++; if (done_cnt !== 1 || last_good !== 1) begin miss++; $display("FAIL good_done got=%0d/%0d exp=1/1", done_cnt, last_good); end
        vec++; if (bus.frame_cnt !== 16'd1 || bus.err_cnt !== 16'd0) begin miss++; $display("FAIL good_counters got=%0d/%0d exp=1/0", bus.frame_cnt, bus.err_cnt); end
        vec++; if (first_valid_cyc !== da_cyc + 6) begin miss++; $display("FAIL good_data_latency got=%0d exp=%0d", first_valid_cyc, da_cyc + 6); end
        vec++; if (done_cyc !== dvlow_cyc + 3) begin miss++; $display("FAIL good_done_latency got=%0d exp=%0d", done_cyc, dvlow_cyc + 3); end
        vec++; if (overlap !== 0) begin miss++; $display("FAIL good_strobe_overlap got=%0d exp=0", overlap); end
    endtask

    task automatic test_crc_error();
        do_reset();
        build_frame(60);
        send_frame(10, -1, -1);
        idle(8);
        vec++; if (got.size() !== 60 || got[10] !== (fr[10] ^ 8'h01)) begin miss++; $display("FAIL crc_err_stream got=%0d bytes exp=60 with byte10 flipped", got.size()); end
        vec++; if (done_cnt !== 1 || last_good !== 0) begin miss++; $display("FAIL crc_err_done got=%0d/%0d exp=1/0", done_cnt, last_good); end
        vec++; if (bus.err_cnt !== 16'd1 || bus.frame_cnt !== 16'd0) begin miss++; $display("FAIL crc_err_counters got=%0d/%0d exp=1/0", bus.err_cnt, bus.frame_cnt); end
    endtask

    task automatic test_rx_er();
        do_reset();
        build_frame(60);
        send_frame(-1, 20, -1);
        idle(8);
        vec++; if (done_cnt !== 1 || last_good !== 0) begin miss++; $display("FAIL rx_er_done got=%0d/%0d exp=1/0", done_cnt, last_good); end
        vec++; if (bus.err_cnt !== 16'd1 || bus.frame_cnt !== 16'd0) begin miss++; $display("FAIL rx_er_counters got=%0d/%0d exp=1/0", bus.err_cnt, bus.frame_cnt); end
    endtask

    task automatic test_preamble_error();
        do_reset();
        drive(1'b1, 8'h55, 1'b0); drive(1'b1, 8'h55, 1'b0); drive(1'b1, 8'hAA, 1'b0);
        for (int i = 0; i < 6; i++) drive(1'b1, 8'(i + 8'h10), 1'b0);
        idle(8);
        vec++; if (got.size() !== 0 || done_cnt !== 0) begin miss++; $display("FAIL pre_err_output got=%0d valid/%0d done exp=0/0", got.size(), done_cnt); end
        vec++; if (bus.err_cnt !== 16'd1 || bus.frame_cnt !== 16'd0) begin miss++; $display("FAIL pre_err_counters got=%0d/%0d exp=1/0", bus.err_cnt, bus.frame_cnt); end
    endtask

    task automatic test_back_to_back();
        int bad_bytes = 0;
        do_reset();
        build_frame(60);
        send_frame(-1, -1, -1);
        send_frame(-1, -1, -1);
        idle(8);
        for (int i = 0; i < got.size() && i < 120; i++) if (got[i] !== fr[i % 60]) bad_bytes++;
        vec++; if (got.size() !== 120 || bad_bytes !== 0) begin miss++; $display("FAIL b2b_stream got=%0d bytes %0d bad exp=120 0", got.size(), bad_bytes); end
        vec++; if (done_cnt !== 2 || good_cnt !== 2 || sof_cnt !== 2) begin miss++; $display("FAIL b2b_done got=%0d done %0d good %0d sof exp=2 2 2", done_cnt, good_cnt, sof_cnt); end
        vec++; if (bus.frame_cnt !== 16'd2 || bus.err_cnt !== 16'd0) begin miss++; $display("FAIL b2b_counters got=%0d/%0d exp=2/0", bus.frame_cnt, bus.err_cnt); end
    endtask

    task automatic test_lengths();
        do_reset();
        build_frame(1515);
        send_frame(-1, -1, -1);
        idle(8);
        vec++; if (got.size() !== 1515 || last_good !== 0 || bus.err_cnt !== 16'd1) begin miss++; $display("FAIL oversize got=%0d bytes good=%0d err=%0d exp=1515 0 1", got.size(), last_good, bus.err_cnt); end
        do_reset();
        build_frame(1514);
        send_frame(-1, -1, -1);
        idle(8);
        vec++; if (last_good !== 1 || bus.frame_cnt !== 16'd1) begin miss++; $display("FAIL max_size got=good%0d cnt%0d exp=good1 cnt1", last_good, bus.frame_cnt); end
        do_reset();
        build_frame(59);
        send_frame(-1, -1, -1);
        idle(8);
        vec++; if (got.size() !== 59 || last_good !== 0 || bus.err_cnt !== 16'd1) begin miss++; $display("FAIL runt63 got=%0d bytes good=%0d err=%0d exp=59 0 1", got.size(), last_good, bus.err_cnt); end
        do_reset();
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hD5, 1'b0); drive(1'b1, 8'h11, 1'b0); drive(1'b1, 8'h22, 1'b0);
        idle(8);
        vec++; if (got.size() !== 0 || sof_cnt !== 0 || done_cnt !== 1 || last_good !== 0) begin miss++; $display("FAIL tiny got=%0d bytes %0d sof %0d done good=%0d exp=0 0 1 0", got.size(), sof_cnt, done_cnt, last_good); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        build_frame(60);
        send_frame(-1, -1, 30);
        idle(8);
        vec++; if (snap_any !== 1'b0 || snap_data !== 8'h00 || snap_cnt !== 16'd0) begin miss++; $display("FAIL midrst_outputs got=%b %h %0d exp=0 00 0", snap_any, snap_data, snap_cnt); end
        vec++; if (got.size() !== 25 || done_cnt !== 0) begin miss++; $display("FAIL midrst_stream got=%0d bytes %0d done exp=25 0", got.size(), done_cnt); end
        vec++; if (bus.err_cnt !== 16'd1 || bus.frame_cnt !== 16'd0) begin miss++; $display("FAIL midrst_drop got=%0d/%0d exp=1/0", bus.err_cnt, bus.frame_cnt); end
        send_frame(-1, -1, -1);
        idle(8);
        vec++; if (bus.frame_cnt !== 16'd1 || bus.err_cnt !== 16'd1 || last_good !== 1) begin miss++; $display("FAIL midrst_next got=%0d/%0d good=%0d exp=1/1 good=1", bus.frame_cnt, bus.err_cnt, last_good); end
    endtask

    initial begin
        bus.gmii_rx_dv = 1'b0; bus.gmii_rxd = 8'h00; bus.gmii_rx_er = 1'b0;
        clear_mon();
        test_reset();
        test_good();
        test_crc_error();
        test_rx_er();
        test_preamble_error();
        test_back_to_back();
        test_lengths();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
